// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared definitions for the BCD converter scheduler: the
//                converter FSM state encoding, the BCD digit width and the
//                double-dabble add-3 threshold/correction constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    // Converter FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Width of one packed BCD digit
    localparam int C_DIGIT_W = 4;

    // A digit at or above this value overflows past 9 when doubled
    localparam logic [C_DIGIT_W-1:0] C_ADD3_THRESH = 4'd5;

    // Correction that makes the following doubling carry into the next digit
    localparam logic [C_DIGIT_W-1:0] C_ADD3_CORR = 4'd3;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_dabble_step.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_dabble_step
//  Description : Combinational double-dabble correction. Each BCD digit that
//                is >= 5 gets 3 added, so the subsequent left shift produces
//                a valid decimal carry.
//  Ports       : digits_raw - packed BCD digits before correction
//                digits_adj - packed BCD digits after correction
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3
)
(
    input  logic [C_DIGIT_W*DIGITS-1:0] digits_raw,
    output logic [C_DIGIT_W*DIGITS-1:0] digits_adj
);

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic [C_DIGIT_W-1:0] w_digit;

        assign w_digit = digits_raw[gi*C_DIGIT_W +: C_DIGIT_W];
        assign digits_adj[gi*C_DIGIT_W +: C_DIGIT_W] =
            (w_digit >= C_ADD3_THRESH) ? (w_digit + C_ADD3_CORR) : w_digit;
    end

endmodule : bcd_dabble_step
`default_nettype wire

// File: rtl/bcd_conv_sched.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_conv_sched
//  Description : One iterative double-dabble binary-to-BCD converter shared
//                by two requesters (0: live temperature, 1: peak-hold) under
//                round-robin arbitration. One value converts in BIN_W+1
//                cycles; the result carries the source tag and is held until
//                the consumer accepts it.
//  Ports       : clk, reset             - clock, synchronous active-high reset
//                req0_valid/data/ready  - requester 0 handshake
//                req1_valid/data/ready  - requester 1 handshake
//                out_valid/out_ready    - result handshake
//                out_bcd                - packed BCD, digit 0 in [3:0]
//                out_tag                - requester that produced the result
//                out_neg                - sign of the converted value
//  Config      : BCD_SIGNED_EN - when defined, request data is two's
//                complement; the magnitude is converted and out_neg flags
//                negative inputs. When undefined out_neg is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_conv_sched
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 9,
    parameter int DIGITS = 3
)
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req0_valid,
    input  logic [BIN_W-1:0]          req0_data,
    output logic                      req0_ready,
    input  logic                      req1_valid,
    input  logic [BIN_W-1:0]          req1_data,
    output logic                      req1_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [C_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                      out_tag,
    output logic                      out_neg
);

    localparam int C_BCD_W = C_DIGIT_W * DIGITS;
    localparam int C_CNT_W = $clog2(BIN_W + 1);

    state_t               r_state;
    logic [BIN_W-1:0]     r_shreg;
    logic [C_BCD_W-1:0]   r_bcd;
    logic [C_CNT_W-1:0]   r_count;
    logic                 r_tag;
    logic                 r_last_grant;
    logic                 r_out_valid;

    logic                 w_grant0;
    logic                 w_grant1;
    logic                 w_accept;
    logic [BIN_W-1:0]     w_sel_data;
    logic [BIN_W-1:0]     w_load_mag;
    logic [C_BCD_W-1:0]   w_bcd_adj;

    // Sole valid requester wins; on contention the one not served last wins.
    assign w_grant0 = req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);

    // Ready is only offered while idle and out of reset.
    assign req0_ready = !reset && (r_state == ST_IDLE) && w_grant0;
    assign req1_ready = !reset && (r_state == ST_IDLE) && w_grant1;
    assign w_accept   = req0_ready || req1_ready;

    assign w_sel_data = w_grant1 ? req1_data : req0_data;

`ifdef BCD_SIGNED_EN
    logic r_neg;
    logic w_load_neg;

    // The most-negative code negates to itself, which read unsigned is
    // exactly its magnitude, so no extra bit is needed.
    assign w_load_neg = w_sel_data[BIN_W-1];
    assign w_load_mag = w_load_neg ? (~w_sel_data + 1'b1) : w_sel_data;
    assign out_neg    = r_neg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= w_load_neg;
        end
    end
`else
    assign w_load_mag = w_sel_data;
    assign out_neg    = 1'b0;
`endif

    bcd_dabble_step #(
        .DIGITS     (DIGITS)
    ) u_dabble_step (
        .digits_raw (r_bcd),
        .digits_adj (w_bcd_adj)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_shreg      <= '0;
            r_bcd        <= '0;
            r_count      <= '0;
            r_tag        <= 1'b0;
            r_last_grant <= 1'b1;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shreg      <= w_load_mag;
                        r_bcd        <= '0;
                        r_count      <= C_CNT_W'(BIN_W);
                        r_tag        <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // Correct first, then shift the next binary MSB into digit 0.
                    {r_bcd, r_shreg} <= {w_bcd_adj, r_shreg} << 1;
                    r_count          <= r_count - 1'b1;
                    if (r_count == C_CNT_W'(1)) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_bcd   = r_bcd;
    assign out_tag   = r_tag;

endmodule : bcd_conv_sched
`default_nettype wire
